// File: rtl/dmni_ni_ctrl_pkg.sv
// Shared types for the DMNI network-interface control block: MMR map, Hermes
// operation, BrLite records and the BrLite transmit FSM states.
package dmni_ni_ctrl_pkg;

  localparam int unsigned DMNI_MMR_SIZE = 64;
  localparam int unsigned DMNI_ADDR_W   = $clog2(DMNI_MMR_SIZE);

  // Monitor pointers occupy DMNI_BR_MON_PTR_BASE .. +7; the perf counters sit past them.
  typedef enum logic [DMNI_ADDR_W-1:0] {
    DMNI_MANYCORE_SIZE       = 6'd0,
    DMNI_ADDRESS             = 6'd1,
    DMNI_IRQ_STATUS          = 6'd2,
    DMNI_IRQ_MASK            = 6'd3,
    DMNI_STATUS              = 6'd4,
    DMNI_PENDING_SVC         = 6'd5,
    DMNI_RELEASE_PERIPHERAL  = 6'd6,
    DMNI_HERMES_START        = 6'd7,
    DMNI_HERMES_OP           = 6'd8,
    DMNI_HERMES_SIZE         = 6'd9,
    DMNI_HERMES_SIZE_2       = 6'd10,
    DMNI_HERMES_ADDRESS      = 6'd11,
    DMNI_HERMES_ADDRESS_2    = 6'd12,
    DMNI_BR_SERVICE          = 6'd13,
    DMNI_BR_KSVC             = 6'd14,
    DMNI_BR_TARGET           = 6'd15,
    DMNI_BR_PRODUCER         = 6'd16,
    DMNI_BR_PAYLOAD          = 6'd17,
    DMNI_BR_START            = 6'd18,
    DMNI_BR_TX_STATUS        = 6'd19,
    DMNI_BR_SVC_POP          = 6'd20,
    DMNI_BR_SVC_HDR          = 6'd21,
    DMNI_BR_SVC_PAYLOAD      = 6'd22,
    DMNI_BR_MON_CLEAR        = 6'd23,
    DMNI_BR_MON_PTR_BASE     = 6'd24,
    DMNI_PERF_BR_TX          = 6'd32,
    DMNI_PERF_BR_RX          = 6'd33
  } dmni_mmr_e;

  typedef enum logic {
    HERMES_OPERATION_SEND    = 1'b0,
    HERMES_OPERATION_RECEIVE = 1'b1
  } hermes_op_t;

  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] target;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_out_t;

  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_REQ  = 1'b1
  } br_tx_state_e;

endpackage

// File: rtl/dmni_ni_ctrl_if.sv
// CPU-side MMR bus of the DMNI control block, plus its interrupt line.
import dmni_ni_ctrl_pkg::*;

interface dmni_ni_ctrl_if;
  logic                   cfg_en;
  logic                   cfg_we;
  logic [DMNI_ADDR_W-1:0] cfg_addr;
  logic [31:0]            cfg_wdata;
  logic [31:0]            cfg_rdata;
  logic                   irq;

  modport master (output cfg_en, cfg_we, cfg_addr, cfg_wdata, input cfg_rdata, irq);
  modport slave  (input cfg_en, cfg_we, cfg_addr, cfg_wdata, output cfg_rdata, irq);
endinterface

// File: rtl/dmni_ni_ctrl_br_tx_fifo.sv
// Generic synchronous FIFO; a pop frees a slot for a same-cycle push even when full.
module dmni_ni_ctrl_br_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + (PTR_W+1)'(1);
        2'b01:   count_o <= count_o - (PTR_W+1)'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/dmni_ni_ctrl.sv
// DMNI network-interface control: MMR bank, Hermes descriptors, BrLite TX queue,
// RX pop, monitor pointers, masked IRQ. `DMNI_NI_PERF_EN adds BrLite TX/RX counters.
//   state   | meaning
//   TX_IDLE | no request on the router port; leaves when the queue is non-empty
//   TX_REQ  | br_req_o high with the queue head held on br_data_o until br_ack_i
import dmni_ni_ctrl_pkg::*;

module dmni_ni_ctrl #(
  parameter int unsigned N_PE_X      = 2,
  parameter int unsigned N_PE_Y      = 2,
  parameter logic [15:0] ADDRESS     = 16'h0000,
  parameter int unsigned N_MON       = 2,
  parameter int unsigned BR_TX_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  dmni_ni_ctrl_if.slave           cfg,
  input  logic                    hermes_send_active_i,
  input  logic                    hermes_receive_active_i,
  input  logic                    hermes_receive_available_i,
  output logic                    hermes_start_o,
  output hermes_op_t              hermes_operation_o,
  output logic [31:0]             hermes_size_o,
  output logic [31:0]             hermes_size_2_o,
  output logic [31:0]             hermes_address_o,
  output logic [31:0]             hermes_address_2_o,
  output logic                    br_mon_clear_o,
  input  logic                    br_mon_clear_ack_i,
  output logic [31:0]             br_mon_task_clear_o,
  output logic [N_MON-1:0][31:0]  br_mon_ptrs_o,
  input  logic                    br_svc_rx_i,
  output logic                    br_svc_ack_o,
  input  brlite_svc_t             br_svc_data_i,
  input  logic                    br_local_busy_i,
  output logic                    br_req_o,
  input  logic                    br_ack_i,
  output brlite_out_t             br_data_o
);

  localparam int unsigned CNT_W = $clog2(BR_TX_DEPTH) + 1;

  logic             wr_en;
  logic             rd_en;
  logic [2:0]       irq_mask;
  logic [2:0]       irq_src;
  logic             pending_svc;
  logic             release_peripheral;
  logic             br_overflow;
  brlite_out_t      br_stage;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  brlite_out_t      fifo_head;
  br_tx_state_e     tx_state;
  logic [31:0]      rdata_next;

  assign wr_en     = cfg.cfg_en && cfg.cfg_we;
  assign rd_en     = cfg.cfg_en && !cfg.cfg_we;
  assign irq_src   = {pending_svc, br_svc_rx_i, hermes_receive_available_i};
  assign fifo_push = wr_en && (cfg.cfg_addr == DMNI_BR_START) && cfg.cfg_wdata[0];
  assign fifo_pop  = (tx_state == TX_REQ) && br_ack_i;

  dmni_ni_ctrl_br_tx_fifo #(
    .DEPTH (BR_TX_DEPTH),
    .T     (brlite_out_t)
  ) u_br_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (br_stage),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef DMNI_NI_PERF_EN
  logic [31:0] perf_br_tx;
  logic [31:0] perf_br_rx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_br_tx <= '0;
      perf_br_rx <= '0;
    end else begin
      if (wr_en && cfg.cfg_addr == DMNI_PERF_BR_TX) perf_br_tx <= '0;
      else if (fifo_pop)                            perf_br_tx <= perf_br_tx + 32'd1;
      if (wr_en && cfg.cfg_addr == DMNI_PERF_BR_RX) perf_br_rx <= '0;
      else if (br_svc_ack_o)                        perf_br_rx <= perf_br_rx + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata_next = '0;
    case (cfg.cfg_addr)
      DMNI_MANYCORE_SIZE:      rdata_next = {16'(N_PE_X), 16'(N_PE_Y)};
      DMNI_ADDRESS:            rdata_next = {16'h0000, ADDRESS};
      DMNI_IRQ_STATUS:         rdata_next = {29'b0, irq_src};
      DMNI_IRQ_MASK:           rdata_next = {29'b0, irq_mask};
      DMNI_STATUS:             rdata_next = {27'b0, release_peripheral, br_mon_clear_o,
                                             br_local_busy_i, hermes_receive_active_i,
                                             hermes_send_active_i};
      DMNI_PENDING_SVC:        rdata_next = {31'b0, pending_svc};
      DMNI_RELEASE_PERIPHERAL: rdata_next = {31'b0, release_peripheral};
      DMNI_HERMES_OP:          rdata_next = {31'b0, hermes_operation_o};
      DMNI_HERMES_SIZE:        rdata_next = hermes_size_o;
      DMNI_HERMES_SIZE_2:      rdata_next = hermes_size_2_o;
      DMNI_HERMES_ADDRESS:     rdata_next = hermes_address_o;
      DMNI_HERMES_ADDRESS_2:   rdata_next = hermes_address_2_o;
      DMNI_BR_SERVICE:         rdata_next = {30'b0, br_stage.service};
      DMNI_BR_KSVC:            rdata_next = {24'b0, br_stage.ksvc};
      DMNI_BR_TARGET:          rdata_next = {16'b0, br_stage.target};
      DMNI_BR_PRODUCER:        rdata_next = {16'b0, br_stage.producer};
      DMNI_BR_PAYLOAD:         rdata_next = br_stage.payload;
      DMNI_BR_TX_STATUS:       rdata_next = {br_overflow, 26'b0, 5'(fifo_count)};
      DMNI_BR_SVC_HDR:         rdata_next = {6'b0, br_svc_data_i.service, br_svc_data_i.ksvc,
                                             br_svc_data_i.producer};
      DMNI_BR_SVC_PAYLOAD:     rdata_next = br_svc_data_i.payload;
      DMNI_BR_MON_CLEAR:       rdata_next = br_mon_task_clear_o;
`ifdef DMNI_NI_PERF_EN
      DMNI_PERF_BR_TX:         rdata_next = perf_br_tx;
      DMNI_PERF_BR_RX:         rdata_next = perf_br_rx;
`endif
      default:                 rdata_next = '0;
    endcase
    for (int i = 0; i < int'(N_MON); i++) begin
      if (cfg.cfg_addr == DMNI_ADDR_W'(int'(DMNI_BR_MON_PTR_BASE) + i))
        rdata_next = br_mon_ptrs_o[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg.cfg_rdata       <= '0;
      cfg.irq             <= 1'b0;
      irq_mask            <= 3'b111;
      pending_svc         <= 1'b0;
      release_peripheral  <= 1'b0;
      hermes_start_o      <= 1'b0;
      hermes_operation_o  <= HERMES_OPERATION_SEND;
      hermes_size_o       <= '0;
      hermes_size_2_o     <= '0;
      hermes_address_o    <= '0;
      hermes_address_2_o  <= '0;
      br_stage            <= '0;
      br_overflow         <= 1'b0;
      br_svc_ack_o        <= 1'b0;
      br_mon_clear_o      <= 1'b0;
      br_mon_task_clear_o <= '0;
      br_mon_ptrs_o       <= '0;
    end else begin
      hermes_start_o <= 1'b0;
      br_svc_ack_o   <= 1'b0;
      cfg.irq        <= |(irq_src & irq_mask);
      if (rd_en) cfg.cfg_rdata <= rdata_next;
      if (fifo_push && fifo_full && !fifo_pop) br_overflow <= 1'b1;
      // The acknowledge wins so a clear request is never lost half-way.
      if (br_mon_clear_ack_i)                             br_mon_clear_o <= 1'b0;
      else if (wr_en && cfg.cfg_addr == DMNI_BR_MON_CLEAR) br_mon_clear_o <= 1'b1;
      if (wr_en) begin
        case (cfg.cfg_addr)
          DMNI_IRQ_MASK:           irq_mask            <= cfg.cfg_wdata[2:0];
          DMNI_PENDING_SVC:        pending_svc         <= cfg.cfg_wdata[0];
          DMNI_RELEASE_PERIPHERAL: release_peripheral  <= cfg.cfg_wdata[0];
          DMNI_HERMES_START:       hermes_start_o      <= cfg.cfg_wdata[0] && !hermes_start_o;
          DMNI_HERMES_OP:          hermes_operation_o  <= hermes_op_t'(cfg.cfg_wdata[0]);
          DMNI_HERMES_SIZE:        hermes_size_o       <= cfg.cfg_wdata;
          DMNI_HERMES_SIZE_2:      hermes_size_2_o     <= cfg.cfg_wdata;
          DMNI_HERMES_ADDRESS:     hermes_address_o    <= cfg.cfg_wdata;
          DMNI_HERMES_ADDRESS_2:   hermes_address_2_o  <= cfg.cfg_wdata;
          DMNI_BR_SERVICE:         br_stage.service    <= cfg.cfg_wdata[1:0];
          DMNI_BR_KSVC:            br_stage.ksvc       <= cfg.cfg_wdata[7:0];
          DMNI_BR_TARGET:          br_stage.target     <= cfg.cfg_wdata[15:0];
          DMNI_BR_PRODUCER:        br_stage.producer   <= cfg.cfg_wdata[15:0];
          DMNI_BR_PAYLOAD:         br_stage.payload    <= cfg.cfg_wdata;
          DMNI_BR_TX_STATUS:       if (cfg.cfg_wdata[31]) br_overflow <= 1'b0;
          DMNI_BR_SVC_POP:         br_svc_ack_o        <= cfg.cfg_wdata[0] && !br_svc_ack_o;
          DMNI_BR_MON_CLEAR:       br_mon_task_clear_o <= cfg.cfg_wdata;
          default:                 ;
        endcase
        for (int i = 0; i < int'(N_MON); i++) begin
          if (cfg.cfg_addr == DMNI_ADDR_W'(int'(DMNI_BR_MON_PTR_BASE) + i))
            br_mon_ptrs_o[i] <= cfg.cfg_wdata;
        end
      end
    end
  end

  // br_data_o is captured on entry to TX_REQ; the head cannot move until the pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state  <= TX_IDLE;
      br_req_o  <= 1'b0;
      br_data_o <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (!fifo_empty) begin
          tx_state  <= TX_REQ;
          br_req_o  <= 1'b1;
          br_data_o <= fifo_head;
        end
        TX_REQ: if (br_ack_i) begin
          tx_state <= TX_IDLE;
          br_req_o <= 1'b0;
        end
        default: begin
          tx_state <= TX_IDLE;
          br_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmni_ni_ctrl.sv
// Scoreboard bench for dmni_ni_ctrl: MMR reads and BrLite transmits are checked by monitors.
import dmni_ni_ctrl_pkg::*;

module tb_dmni_ni_ctrl;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             hermes_send_active_i = 1'b0;
  logic             hermes_receive_active_i = 1'b0;
  logic             hermes_receive_available_i = 1'b0;
  logic             hermes_start_o;
  hermes_op_t       hermes_operation_o;
  logic [31:0]      hermes_size_o, hermes_size_2_o, hermes_address_o, hermes_address_2_o;
  logic             br_mon_clear_o;
  logic             br_mon_clear_ack_i = 1'b0;
  logic [31:0]      br_mon_task_clear_o;
  logic [1:0][31:0] br_mon_ptrs_o;
  logic             br_svc_rx_i = 1'b0;
  logic             br_svc_ack_o;
  brlite_svc_t      br_svc_data_i = '0;
  logic             br_local_busy_i = 1'b0;
  logic             br_req_o;
  logic             br_ack_i = 1'b0;
  brlite_out_t      br_data_o;

  dmni_ni_ctrl_if cfg_if ();

  dmni_ni_ctrl #(
    .N_PE_X(2), .N_PE_Y(2), .ADDRESS(16'h0101), .N_MON(2), .BR_TX_DEPTH(4)
  ) dut (
    .clk_i                      (clk_i),
    .rst_ni                     (rst_ni),
    .cfg                        (cfg_if.slave),
    .hermes_send_active_i       (hermes_send_active_i),
    .hermes_receive_active_i    (hermes_receive_active_i),
    .hermes_receive_available_i (hermes_receive_available_i),
    .hermes_start_o             (hermes_start_o),
    .hermes_operation_o         (hermes_operation_o),
    .hermes_size_o              (hermes_size_o),
    .hermes_size_2_o            (hermes_size_2_o),
    .hermes_address_o           (hermes_address_o),
    .hermes_address_2_o         (hermes_address_2_o),
    .br_mon_clear_o             (br_mon_clear_o),
    .br_mon_clear_ack_i         (br_mon_clear_ack_i),
    .br_mon_task_clear_o        (br_mon_task_clear_o),
    .br_mon_ptrs_o              (br_mon_ptrs_o),
    .br_svc_rx_i                (br_svc_rx_i),
    .br_svc_ack_o               (br_svc_ack_o),
    .br_svc_data_i              (br_svc_data_i),
    .br_local_busy_i            (br_local_busy_i),
    .br_req_o                   (br_req_o),
    .br_ack_i                   (br_ack_i),
    .br_data_o                  (br_data_o)
  );

  always #5 clk_i = ~clk_i;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  brlite_out_t tx_exp_q [$];
  logic        rd_seen = 1'b0;
  logic [31:0] rd_exp;
  string       rd_name;
  brlite_out_t tx_exp;
  brlite_out_t rec;

  // Read monitor: data appears the edge after the access was sampled.
  always @(posedge clk_i) rd_seen <= cfg_if.cfg_en && !cfg_if.cfg_we;

  always @(negedge clk_i) begin
    if (rd_seen) begin
      tests++;
      if (rd_exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got %h with no read outstanding", cfg_if.cfg_rdata);
      end else begin
        rd_exp  = rd_exp_q.pop_front();
        rd_name = rd_name_q.pop_front();
        if (cfg_if.cfg_rdata !== rd_exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", rd_name, cfg_if.cfg_rdata, rd_exp);
        end
      end
    end
  end

  // Transmit monitor: every accepted request must carry the next queued record.
  always @(negedge clk_i) begin
    if (rst_ni && br_req_o && br_ack_i) begin
      tests++;
      if (tx_exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: got %h with nothing queued", br_data_o);
      end else begin
        tx_exp = tx_exp_q.pop_front();
        if (br_data_o !== tx_exp) begin
          fails++;
          $display("FAIL tx_data: got %h expected %h", br_data_o, tx_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    cfg_if.cfg_en = 1'b1; cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = a; cfg_if.cfg_wdata = d;
    cyc();
    cfg_if.cfg_en = 1'b0; cfg_if.cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string n);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(n);
    cfg_if.cfg_en = 1'b1; cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = a;
    cyc();
    cfg_if.cfg_en = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (br_req_o) return;
      cyc();
    end
    tests++;
    fails++;
    $display("FAIL req_timeout: got br_req_o=0 expected 1 within 20 cycles");
  endtask

  task automatic ack_one();
    wait_req();
    br_ack_i = 1'b1;
    cyc();
    br_ack_i = 1'b0;
  endtask

  logic [5:0] mon1, mon2;

  initial begin
    cfg_if.cfg_en = 1'b0; cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_wdata = '0;
    mon1 = 6'(int'(DMNI_BR_MON_PTR_BASE) + 1);
    mon2 = 6'(int'(DMNI_BR_MON_PTR_BASE) + 2);
    repeat (3) cyc();
    rst_ni = 1'b1;
    cyc();

    chk("rst_req", {31'b0, br_req_o}, 32'd0);
    chk("rst_hstart", {31'b0, hermes_start_o}, 32'd0);
    chk("rst_hop", {31'b0, hermes_operation_o}, 32'd0);
    chk("rst_irq", {31'b0, cfg_if.irq}, 32'd0);
    rd(DMNI_IRQ_MASK, 32'd7, "rst_mask");
    rd(DMNI_BR_TX_STATUS, 32'd0, "rst_txstat");
    rd(DMNI_ADDRESS, 32'h0000_0101, "address");
    rd(DMNI_MANYCORE_SIZE, 32'h0002_0002, "manycore");
    rd(6'd63, 32'd0, "unmapped");

    // Hermes start pulse and re-trigger guard
    wr(DMNI_HERMES_START, 32'd1);
    chk("hstart_pulse", {31'b0, hermes_start_o}, 32'd1);
    wr(DMNI_HERMES_START, 32'd1);
    chk("hstart_ignored", {31'b0, hermes_start_o}, 32'd0);
    wr(DMNI_HERMES_SIZE, 32'h40);
    chk("hsize_out", hermes_size_o, 32'h40);
    rd(DMNI_HERMES_SIZE, 32'h40, "hsize_rd");
    wr(DMNI_HERMES_OP, 32'd1);
    chk("hop_recv", {31'b0, hermes_operation_o}, 32'd1);
    br_local_busy_i = 1'b1; hermes_send_active_i = 1'b1;
    rd(DMNI_STATUS, 32'd5, "status_busy");
    br_local_busy_i = 1'b0; hermes_send_active_i = 1'b0;

    // Three queued transmits of the same record
    wr(DMNI_BR_SERVICE, 32'd2);
    wr(DMNI_BR_KSVC, 32'h11);
    wr(DMNI_BR_TARGET, 32'h0203);
    wr(DMNI_BR_PRODUCER, 32'h0101);
    wr(DMNI_BR_PAYLOAD, 32'hCAFE_0001);
    rec = '{service: 2'd2, ksvc: 8'h11, target: 16'h0203, producer: 16'h0101, payload: 32'hCAFE_0001};
    for (int k = 0; k < 3; k++) begin
      wr(DMNI_BR_START, 32'd1);
      tx_exp_q.push_back(rec);
    end
    rd(DMNI_BR_TX_STATUS, 32'd3, "txstat_3");
    chk("req_held", {31'b0, br_req_o}, 32'd1);
    chk("head_payload", br_data_o.payload, 32'hCAFE_0001);
    for (int k = 0; k < 3; k++) begin
      ack_one();
      chk("req_gap", {31'b0, br_req_o}, 32'd0);
    end
    cyc();
    rd(DMNI_BR_TX_STATUS, 32'd0, "txstat_drained");

    // Overflow: five pushes into four entries, no ack
    for (int k = 0; k < 5; k++) begin
      wr(DMNI_BR_PAYLOAD, 32'hA0 + k);
      wr(DMNI_BR_START, 32'd1);
      rec.payload = 32'hA0 + k;
      if (k < 4) tx_exp_q.push_back(rec);
    end
    rd(DMNI_BR_TX_STATUS, 32'h8000_0004, "txstat_ovf");
    wr(DMNI_BR_TX_STATUS, 32'h8000_0000);
    rd(DMNI_BR_TX_STATUS, 32'd4, "txstat_ovf_clr");

    // Drain two, then reset while the third is requested
    ack_one();
    ack_one();
    wait_req();
    #2 rst_ni = 1'b0;
    #1 chk("req_async_rst", {31'b0, br_req_o}, 32'd0);
    tx_exp_q.delete();
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();
    cyc();
    chk("req_after_rst", {31'b0, br_req_o}, 32'd0);
    rd(DMNI_BR_TX_STATUS, 32'd0, "txstat_flushed");
    rd(DMNI_IRQ_MASK, 32'd7, "mask_after_rst");

    // Masked interrupt
    wr(DMNI_IRQ_MASK, 32'd2);
    hermes_receive_available_i = 1'b1;
    cyc();
    cyc();
    chk("irq_masked", {31'b0, cfg_if.irq}, 32'd0);
    rd(DMNI_IRQ_STATUS, 32'd1, "irqstat_1");
    br_svc_rx_i = 1'b1;
    chk("irq_latency", {31'b0, cfg_if.irq}, 32'd0);
    cyc();
    chk("irq_rx", {31'b0, cfg_if.irq}, 32'd1);
    rd(DMNI_IRQ_STATUS, 32'd3, "irqstat_3");
    br_svc_rx_i = 1'b0; hermes_receive_available_i = 1'b0;
    br_svc_data_i = '{service: 2'd1, ksvc: 8'h22, producer: 16'h0304, payload: 32'h1234_5678};
    cyc();
    cyc();
    chk("irq_idle", {31'b0, cfg_if.irq}, 32'd0);
    rd(DMNI_BR_SVC_HDR, 32'h0122_0304, "svc_hdr");
    rd(DMNI_BR_SVC_PAYLOAD, 32'h1234_5678, "svc_payload");

    // RX pop pulse and back-to-back guard
    wr(DMNI_BR_SVC_POP, 32'd1);
    chk("pop_pulse", {31'b0, br_svc_ack_o}, 32'd1);
    wr(DMNI_BR_SVC_POP, 32'd1);
    chk("pop_ignored", {31'b0, br_svc_ack_o}, 32'd0);
    wr(DMNI_PENDING_SVC, 32'd1);
    rd(DMNI_IRQ_STATUS, 32'd4, "irqstat_pend");
    wr(DMNI_IRQ_MASK, 32'd4);
    cyc();
    chk("irq_pend", {31'b0, cfg_if.irq}, 32'd1);
    wr(DMNI_PENDING_SVC, 32'd0);

    // Monitor pointers
    wr(mon1, 32'h1000);
    chk("mon_ptr1", br_mon_ptrs_o[1], 32'h1000);
    wr(mon2, 32'hDEAD);
    chk("mon_ptr0_kept", br_mon_ptrs_o[0], 32'd0);
    chk("mon_ptr1_kept", br_mon_ptrs_o[1], 32'h1000);
    rd(mon2, 32'd0, "mon_ptr2_rd");
    rd(mon1, 32'h1000, "mon_ptr1_rd");

    // Monitor clear with acknowledge priority
    br_mon_clear_ack_i = 1'b1;
    wr(DMNI_BR_MON_CLEAR, 32'd5);
    chk("clear_ack_prio", {31'b0, br_mon_clear_o}, 32'd0);
    br_mon_clear_ack_i = 1'b0;
    wr(DMNI_BR_MON_CLEAR, 32'd7);
    chk("clear_set", {31'b0, br_mon_clear_o}, 32'd1);
    chk("clear_task", br_mon_task_clear_o, 32'd7);
    rd(DMNI_STATUS, 32'd8, "status_clear");
    br_mon_clear_ack_i = 1'b1;
    cyc();
    br_mon_clear_ack_i = 1'b0;
    chk("clear_acked", {31'b0, br_mon_clear_o}, 32'd0);

    // One transmit after reset; staging fields other than payload are back at 0
    wr(DMNI_BR_PAYLOAD, 32'h5555_AAAA);
    wr(DMNI_BR_START, 32'd1);
    tx_exp_q.push_back('{service: 2'd0, ksvc: 8'h00, target: 16'h0000, producer: 16'h0000,
                         payload: 32'h5555_AAAA});
    ack_one();
    cyc();
`ifdef DMNI_NI_PERF_EN
    rd(DMNI_PERF_BR_TX, 32'd1, "perf_tx");
    rd(DMNI_PERF_BR_RX, 32'd1, "perf_rx");
    wr(DMNI_PERF_BR_TX, 32'd0);
    rd(DMNI_PERF_BR_TX, 32'd0, "perf_tx_clr");
`else
    rd(DMNI_PERF_BR_TX, 32'd0, "perf_tx_absent");
    rd(DMNI_PERF_BR_RX, 32'd0, "perf_rx_absent");
`endif

    cyc();
    cyc();
    chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
